sd_audio_buf_sched: RTL and testbench
=====================================

Name: sd_audio_buf_sched

Overview:
- Single-clock scheduler for the SD-card audio playback path.
- Sequences SD sector reads into a two-half (ping-pong) 8 KB byte RAM and generates the RAM write address.
- Tracks the fill state of each half, releases a half once the WAV reader has consumed it, and generates the RAM read address for 16-bit sample fetches.
- Sits between the SD sector reader and the byte RAM / WAV output stage.

Parameters:
- SADDR, 32'd8256: first sector of the audio file.
- OADDR, 32'd15269887: last sector; the sector after it wraps to SADDR.
- HALF_BYTES, 4096: bytes per buffer half (power of two). RAM depth is 2*HALF_BYTES.
- STARTUP_WAIT, 1023: cycles to wait after init rises before the first read.

Ports:
- clk_50M  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  SD card initialised (level). Low forces IDLE.
- read_SD  out  1  sector read request; held high while a half is being filled.
- read_sec  out  32  sector address for the current read.
- data_come  in  1  1-cycle pulse per sector accepted by the SD reader; advances read_sec.
- myvalid  in  1  byte strobe from the SD reader.
- ram_wen  out  1  RAM write enable (combinational: myvalid and fill state active).
- ram_waddr  out  13  RAM write address.
- wav_rden  in  1  sample read strobe from the WAV stage.
- ram_raddr  out  13  RAM read address (even); RAM returns {mem[raddr+1], mem[raddr]}.
- play_en  out  1  playback allowed.
- half_full  out  2  bit n = half n holds unconsumed data.
- underrun  out  1  1-cycle pulse when a read is refused.
- loop_wrap  out  1  1-cycle pulse when read_sec wraps OADDR -> SADDR.

Behaviour:
- Reset (rst=1): state=IDLE, read_SD=0, read_sec=SADDR, ram_waddr=0, ram_raddr=0, play_en=0, half_full=0, underrun=0, loop_wrap=0, startup counter=0.
- init=0 in any state has the same effect as rst, except read_sec is held.

State machine:
- IDLE: go to WAIT when init=1.
- WAIT: count STARTUP_WAIT cycles. On the terminal count, load read_sec=SADDR, set ram_waddr=0, go to FILL0.
- FILL0 / FILL1: read_SD=1 (registered; high from the first cycle in the state).
  - Each myvalid writes at ram_waddr, then ram_waddr+1 (13-bit, wraps 8191 -> 0).
  - When myvalid coincides with ram_waddr = HALF_BYTES-1 (FILL0) or 2*HALF_BYTES-1 (FILL1): set half_full[n], drop read_SD next cycle, then move on.
  - Next state is FILL(other) if half_full[other]=0 (after any same-cycle release), else HOLDn.
- HOLD0 / HOLD1: read_SD=0. Go to FILL(other) in the cycle after half_full[other] clears.

Sector and write rules:
- Sector address on data_come in any active state: read_sec+1 if read_sec<OADDR, else SADDR with a loop_wrap pulse.
- myvalid outside FILL states is ignored: no write, no address change.

Read side:
- play_en sets when half_full[0] first sets after reset/init. It stays set until rst or init=0.
- On wav_rden with play_en=1 and half_full[ram_raddr[12]]=1: ram_raddr += 2 (wraps 8190 -> 0).
  - If the old ram_raddr was HALF_BYTES-2 or 2*HALF_BYTES-2, clear half_full for that half in the same edge.
- On wav_rden with play_en=1 and the current half empty: ram_raddr holds and underrun pulses.
- wav_rden with play_en=0: ignored, no underrun.
- Same-cycle half_full set (fill done) and clear (release) act on different halves; both apply.
- Sample data latency is the RAM's concern. This block only guarantees ram_raddr is stable in the cycle wav_rden is sampled.

Test Plan:
- Startup: rst, then init=1 -> read_SD rises 1024 cycles later, read_sec=8256. After 4096 myvalid bytes: half_full=01, play_en=1, state FILL1, read_SD stays high.
- Continuous fill, no reads: 8192 bytes -> half_full=11, read_SD=0 (HOLD0). A further myvalid leaves ram_waddr at 0.
- Release: from HOLD0, 2048 wav_rden -> half_full[0] clears on the 2048th. read_SD=1 next cycle, ram_raddr=4096, the first new byte is written at 0.
- Underrun: with half_full=00 and play_en=1, wav_rden -> underrun pulse, ram_raddr unchanged.
- Sector wrap: force read_sec=15269887, pulse data_come -> read_sec=8256, loop_wrap=1 for one cycle.
- Mid-operation: rst during FILL1 (ram_waddr=5000) -> all outputs return to reset values next edge. Same for init=0, except read_sec is unchanged.

Source files
------------

// File: rtl/sd_audio_buf_sched_if.sv
// sd_audio_buf_sched_if: SD reader, byte RAM and WAV-stage signals of the audio buffer scheduler
// master = scheduler side (drives read_SD, read_sec, ram_wen, ram_waddr, ram_raddr, play_en, half_full, underrun, loop_wrap)
// slave  = environment side (drives init, data_come, myvalid, wav_rden)
interface sd_audio_buf_sched_if;
  logic init, read_SD, data_come, myvalid, ram_wen, wav_rden, play_en, underrun, loop_wrap;
  logic [31:0] read_sec;
  logic [12:0] ram_waddr, ram_raddr;
  logic [1:0] half_full;
  modport master(
    input init, data_come, myvalid, wav_rden,
    output read_SD, read_sec, ram_wen, ram_waddr, ram_raddr, play_en, half_full, underrun, loop_wrap
  );
  modport slave(
    output init, data_come, myvalid, wav_rden,
    input read_SD, read_sec, ram_wen, ram_waddr, ram_raddr, play_en, half_full, underrun, loop_wrap
  );
endinterface

// File: rtl/sd_audio_buf_sched.sv
// sd_audio_buf_sched: ping-pong SD sector fill / WAV read scheduler for an 8 KB byte RAM
// clk_50M, rst (sync, active high); bus (master): init/data_come/myvalid/wav_rden in,
// read_SD/read_sec/ram_wen/ram_waddr/ram_raddr/play_en/half_full/underrun/loop_wrap out
module sd_audio_buf_sched #(
  parameter logic [31:0] SADDR = 32'd8256,
  parameter logic [31:0] OADDR = 32'd15269887,
  parameter int HALF_BYTES = 4096,
  parameter int STARTUP_WAIT = 1023
) (
  input logic clk_50M,
  input logic rst,
  sd_audio_buf_sched_if.master bus
);
  localparam int HB = $clog2(HALF_BYTES);
  localparam int CW = $clog2(STARTUP_WAIT + 1);
  localparam logic [12:0] W_END0 = 13'(HALF_BYTES - 1);
  localparam logic [12:0] W_END1 = 13'(2 * HALF_BYTES - 1);
  localparam logic [12:0] R_END0 = 13'(HALF_BYTES - 2);
  localparam logic [12:0] R_END1 = 13'(2 * HALF_BYTES - 2);
  // HOLDn waits for half n to be released, then refills it
  typedef enum logic [2:0] {IDLE, WAIT, FILL0, FILL1, HOLD0, HOLD1} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic fill, wr, fill_done, wait_done, rd_hit, rd_ok, sec_adv, clr;
  logic [1:0] hf_set, hf_clr, hf_nx;
  assign fill = state == FILL0 || state == FILL1;
  assign wr = fill && bus.myvalid;
  assign fill_done = wr && bus.ram_waddr == (state == FILL0 ? W_END0 : W_END1);
  assign hf_set = {fill_done && state == FILL1, fill_done && state == FILL0};
  assign wait_done = state == WAIT && cnt == CW'(STARTUP_WAIT - 1);
  assign rd_hit = bus.wav_rden && bus.play_en;
  assign rd_ok = rd_hit && bus.half_full[bus.ram_raddr[HB]];
  assign clr = rd_ok && (bus.ram_raddr == R_END0 || bus.ram_raddr == R_END1);
  assign hf_clr = clr ? (bus.ram_raddr[HB] ? 2'b10 : 2'b01) : 2'b00;
  // fill done and release always target different halves, so both apply
  assign hf_nx = (bus.half_full | hf_set) & ~hf_clr;
  assign sec_adv = bus.data_come && state != IDLE && !wait_done;
  always_ff @(posedge clk_50M)
    state <= (rst || !bus.init) ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.init ? WAIT : IDLE;
      WAIT: state_nx = wait_done ? FILL0 : WAIT;
      FILL0: state_nx = !fill_done ? FILL0 : hf_nx[1] ? HOLD1 : FILL1;
      FILL1: state_nx = !fill_done ? FILL1 : hf_nx[0] ? HOLD0 : FILL0;
      HOLD0: state_nx = bus.half_full[0] ? HOLD0 : FILL0;
      HOLD1: state_nx = bus.half_full[1] ? HOLD1 : FILL1;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.read_SD = fill;
  assign bus.ram_wen = wr;
  always_ff @(posedge clk_50M)
    if (rst || !bus.init) begin
      cnt <= '0;
      bus.ram_waddr <= '0;
      bus.ram_raddr <= '0;
      bus.play_en <= 1'b0;
      bus.half_full <= 2'b00;
      bus.underrun <= 1'b0;
      bus.loop_wrap <= 1'b0;
      if (rst) bus.read_sec <= SADDR;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      bus.ram_waddr <= wait_done ? 13'd0 : wr ? bus.ram_waddr + 13'd1 : bus.ram_waddr;
      bus.ram_raddr <= rd_ok ? bus.ram_raddr + 13'd2 : bus.ram_raddr;
      bus.half_full <= hf_nx;
      bus.play_en <= bus.play_en | hf_set[0];
      bus.underrun <= rd_hit && !rd_ok;
      bus.loop_wrap <= sec_adv && bus.read_sec >= OADDR;
      bus.read_sec <= wait_done ? SADDR : !sec_adv ? bus.read_sec : bus.read_sec < OADDR ? bus.read_sec + 32'd1 : SADDR;
    end
endmodule

// File: tb/tb_sd_audio_buf_sched.sv
// tb_sd_audio_buf_sched: directed self-checking bench for sd_audio_buf_sched
module tb_sd_audio_buf_sched;
  logic clk_50M = 1'b0;
  logic rst;
  int n_cmp = 0, n_err = 0;
  sd_audio_buf_sched_if bus();
  // OADDR lowered so the sector wrap is reachable with a few data_come pulses
  sd_audio_buf_sched #(.OADDR(32'd8259)) dut (.clk_50M(clk_50M), .rst(rst), .bus(bus));
  always #10 clk_50M = ~clk_50M;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask
  task automatic bytes(input int n);
    bus.myvalid = 1'b1;
    cyc(n);
    bus.myvalid = 1'b0;
  endtask
  task automatic reads(input int n);
    bus.wav_rden = 1'b1;
    cyc(n);
    bus.wav_rden = 1'b0;
  endtask
  task automatic secs(input int n);
    repeat (n) begin
      bus.data_come = 1'b1;
      cyc(1);
      bus.data_come = 1'b0;
      cyc(1);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.init = 1'b0;
    bus.data_come = 1'b0;
    bus.myvalid = 1'b0;
    bus.wav_rden = 1'b0;
    cyc(3);
    chk("rst_read_SD", bus.read_SD, 0);
    chk("rst_read_sec", bus.read_sec, 8256);
    chk("rst_waddr", bus.ram_waddr, 0);
    chk("rst_raddr", bus.ram_raddr, 0);
    chk("rst_play_en", bus.play_en, 0);
    chk("rst_half_full", bus.half_full, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_loop_wrap", bus.loop_wrap, 0);
    rst = 1'b0;
    bus.init = 1'b1;
    bus.myvalid = 1'b1;
    bus.wav_rden = 1'b1;
    cyc(1023);
    chk("wait_read_SD", bus.read_SD, 0);
    chk("wait_ram_wen", bus.ram_wen, 0);
    chk("wait_waddr_ignored", bus.ram_waddr, 0);
    chk("wait_no_underrun", bus.underrun, 0);
    bus.myvalid = 1'b0;
    bus.wav_rden = 1'b0;
    cyc(1);
    chk("start_read_SD", bus.read_SD, 1);
    chk("start_read_sec", bus.read_sec, 8256);
    secs(3);
    chk("sec_advance", bus.read_sec, 8259);
    chk("sec_no_wrap", bus.loop_wrap, 0);
    bus.data_come = 1'b1;
    cyc(1);
    bus.data_come = 1'b0;
    chk("wrap_read_sec", bus.read_sec, 8256);
    chk("wrap_pulse", bus.loop_wrap, 1);
    cyc(1);
    chk("wrap_pulse_end", bus.loop_wrap, 0);
    bus.myvalid = 1'b1;
    #1;
    chk("fill_ram_wen", bus.ram_wen, 1);
    cyc(4095);
    bus.myvalid = 1'b0;
    chk("fill0_waddr", bus.ram_waddr, 4095);
    chk("fill0_not_full", bus.half_full, 0);
    chk("fill0_no_play", bus.play_en, 0);
    bytes(1);
    chk("fill0_done_hf", bus.half_full, 1);
    chk("fill0_done_play", bus.play_en, 1);
    chk("fill1_read_SD", bus.read_SD, 1);
    chk("fill1_waddr", bus.ram_waddr, 4096);
    bytes(4096);
    chk("hold_hf", bus.half_full, 3);
    chk("hold_read_SD", bus.read_SD, 0);
    chk("hold_waddr", bus.ram_waddr, 0);
    bus.myvalid = 1'b1;
    #1;
    chk("hold_ram_wen", bus.ram_wen, 0);
    cyc(1);
    bus.myvalid = 1'b0;
    chk("hold_waddr_ignored", bus.ram_waddr, 0);
    reads(2047);
    chk("rel_raddr_pre", bus.ram_raddr, 4094);
    chk("rel_hf_pre", bus.half_full, 3);
    reads(1);
    chk("rel_hf", bus.half_full, 2);
    chk("rel_raddr", bus.ram_raddr, 4096);
    cyc(1);
    chk("refill_read_SD", bus.read_SD, 1);
    bus.myvalid = 1'b1;
    #1;
    chk("refill_ram_wen", bus.ram_wen, 1);
    chk("refill_first_addr", bus.ram_waddr, 0);
    cyc(1);
    bus.myvalid = 1'b0;
    chk("refill_waddr", bus.ram_waddr, 1);
    reads(2048);
    chk("rd1_raddr_wrap", bus.ram_raddr, 0);
    chk("rd1_hf", bus.half_full, 0);
    reads(1);
    chk("underrun_pulse", bus.underrun, 1);
    chk("underrun_raddr", bus.ram_raddr, 0);
    cyc(1);
    chk("underrun_end", bus.underrun, 0);
    bytes(4095);
    chk("mid_fill1_hf", bus.half_full, 1);
    bytes(904);
    chk("mid_waddr", bus.ram_waddr, 5000);
    chk("mid_read_SD", bus.read_SD, 1);
    secs(2);
    chk("mid_read_sec", bus.read_sec, 8258);
    bus.init = 1'b0;
    cyc(1);
    chk("init0_read_SD", bus.read_SD, 0);
    chk("init0_read_sec_held", bus.read_sec, 8258);
    chk("init0_waddr", bus.ram_waddr, 0);
    chk("init0_hf", bus.half_full, 0);
    chk("init0_play_en", bus.play_en, 0);
    bus.init = 1'b1;
    cyc(1024);
    chk("restart_read_SD", bus.read_SD, 1);
    chk("restart_read_sec", bus.read_sec, 8256);
    bytes(5000);
    reads(3);
    secs(1);
    chk("pre_rst_waddr", bus.ram_waddr, 5000);
    chk("pre_rst_raddr", bus.ram_raddr, 6);
    chk("pre_rst_read_sec", bus.read_sec, 8257);
    rst = 1'b1;
    cyc(1);
    chk("mrst_read_SD", bus.read_SD, 0);
    chk("mrst_read_sec", bus.read_sec, 8256);
    chk("mrst_waddr", bus.ram_waddr, 0);
    chk("mrst_raddr", bus.ram_raddr, 0);
    chk("mrst_play_en", bus.play_en, 0);
    chk("mrst_hf", bus.half_full, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
